// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-fetch path.
//   state_e   : responder FSM encodings (IDLE/WAIT/RESP)
//   NOP       : instruction returned on a faulting fetch (addi x0,x0,0)
//   NEW_PC    : PC mux select, take redirect target
//   PC_PLUS4  : PC mux select, sequential fetch
//   addr_ok() : word-aligned and inside a DEPTH-word array
package imem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam logic [31:0] NOP      = 32'h00000013;

  localparam logic [1:0]  PC_PLUS4 = 2'b00;
  localparam logic [1:0]  NEW_PC   = 2'b01;

  // True when a byte address names a whole word that exists in the array.
  function automatic logic addr_ok(input logic [31:0] a, input int unsigned depth);
    return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < 32'(depth));
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: DEPTH x 32, one synchronous write port, one
// combinational read port. Contents have no reset so a preloaded program
// survives a responder reset.
//   clk     : write clock
//   wr_en   : write strobe (caller guarantees wr_addr is in range)
//   wr_addr : word index to write
//   wr_data : word to write
//   rd_addr : word index to read
//   rd_data : word at rd_addr, combinational
module imem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read is combinational, so a write landing on the same edge as the
  // consumer's sampling edge is not yet visible to it.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory responder. One request outstanding at a
// time; the response appears exactly LATENCY edges after acceptance and is
// held until the consumer takes it.
//   clk       : clock, all state changes on rising edge
//   rst_n     : synchronous active-low reset
//   req_valid : fetch request valid
//   req_ready : high only in IDLE
//   req_addr  : byte address of the instruction
//   rsp_valid : high only in RESP
//   rsp_ready : consumer accepts the response
//   rsp_instr : fetched word (NOP on error)
//   rsp_err   : address misaligned or beyond DEPTH words
//   ld_en     : preload write enable
//   ld_addr   : preload byte address (word-aligned, in range, else ignored)
//   ld_data   : preload word
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised by the responder, holds with its payload
// stable until that edge.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q,   cnt_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q,   err_d;

  logic        rd_ok;
  logic        ld_ok;
  logic [31:0] rd_data;

  assign rd_ok = addr_ok(addr_q, DEPTH);
  assign ld_ok = ld_en && addr_ok(ld_addr, DEPTH);

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .wr_en   (ld_ok),
    .wr_addr (ld_addr[AW+1:2]),
    .wr_data (ld_data),
    .rd_addr (addr_q[AW+1:2]),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          // Faulting addresses never use the array word.
          err_d   = !rd_ok;
          instr_d = rd_ok ? rd_data : NOP;
          state_d = RESP;
        end
      end
      RESP: begin
        // Returning to IDLE here means a request waiting on this edge is
        // only seen on the following one.
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 32'd0;
      instr_q <= NOP;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_instr = instr_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam logic [31:0] NOP_W = 32'h00000013;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_err;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_responder #(
    .DEPTH   (256),
    .LATENCY (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_err   (rsp_err),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_en   = 1'b0;
  endtask

  // Request, then wait (bounded) for rsp_valid and check the latency.
  task automatic fetch(input string tag, input logic [31:0] a);
    int lat;
    req_valid = 1'b1;
    req_addr  = a;
    step();
    req_valid = 1'b0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd2);
  endtask

  task automatic take(input string tag);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'd0;
    rsp_ready = 1'b0;
    ld_en     = 1'b0;
    ld_addr   = 32'd0;
    ld_data   = 32'd0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_instr", rsp_instr, NOP_W);
    chk("rst_rsp_err",   32'(rsp_err), 32'd0);

    // Preload, including two writes that must be dropped.
    preload(32'h0000_0000, 32'h0050_0093);
    preload(32'h0000_0004, 32'h00A0_0113);
    preload(32'h0000_03FC, 32'hCAFE_F00D);
    preload(32'h0000_0002, 32'hBAD0_0001);
    preload(32'h0000_0400, 32'hBAD0_0002);

    // Fetch 0 with explicit per-edge checks.
    req_valid = 1'b1;
    req_addr  = 32'h0;
    step();
    req_valid = 1'b0;
    chk("f0_k_ready", 32'(req_ready), 32'd0);
    chk("f0_k_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("f0_k1_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("f0_k2_valid", 32'(rsp_valid), 32'd1);
    chk("f0_instr",    rsp_instr, 32'h0050_0093);
    chk("f0_err",      32'(rsp_err), 32'd0);
    take("f0");

    fetch("mis", 32'h0000_0002);
    chk("mis_err",   32'(rsp_err), 32'd1);
    chk("mis_instr", rsp_instr, NOP_W);
    take("mis");

    fetch("oor", 32'h0000_0400);
    chk("oor_err",   32'(rsp_err), 32'd1);
    chk("oor_instr", rsp_instr, NOP_W);
    take("oor");

    fetch("last", 32'h0000_03FC);
    chk("last_err",   32'(rsp_err), 32'd0);
    chk("last_instr", rsp_instr, 32'hCAFE_F00D);
    take("last");

    // Backpressure with a preload to the latched address while in RESP.
    fetch("bp", 32'h0000_0004);
    chk("bp_instr0", rsp_instr, 32'h00A0_0113);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        ld_en   = 1'b1;
        ld_addr = 32'h4;
        ld_data = 32'hDEAD_BEEF;
      end else begin
        ld_en = 1'b0;
      end
      step();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_instr", rsp_instr, 32'h00A0_0113);
      chk("bp_err",   32'(rsp_err), 32'd0);
    end
    ld_en = 1'b0;
    // Release with a request already pending: not accepted on this edge.
    req_valid = 1'b1;
    req_addr  = 32'h0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("bp_rel_ready", 32'(req_ready), 32'd1);
    chk("bp_rel_valid", 32'(rsp_valid), 32'd0);
    step();
    req_valid = 1'b0;
    chk("bp_acc_ready", 32'(req_ready), 32'd0);
    step();
    step();
    chk("bp_f0_valid", 32'(rsp_valid), 32'd1);
    chk("bp_f0_instr", rsp_instr, 32'h0050_0093);
    take("bp_f0");

    // The RESP-time write did land in the array.
    fetch("bp_chk", 32'h0000_0004);
    chk("bp_chk_instr", rsp_instr, 32'hDEAD_BEEF);
    take("bp_chk");

    // Race: write during WAIT before the latch edge is visible.
    preload(32'h4, 32'h00A0_0113);
    req_valid = 1'b1;
    req_addr  = 32'h4;
    step();
    req_valid = 1'b0;
    ld_en   = 1'b1;
    ld_addr = 32'h4;
    ld_data = 32'hDEAD_BEEF;
    step();
    ld_en = 1'b0;
    step();
    chk("race_w_valid", 32'(rsp_valid), 32'd1);
    chk("race_w_instr", rsp_instr, 32'hDEAD_BEEF);
    take("race_w");

    // Race: write on the latch edge itself returns the old word.
    req_valid = 1'b1;
    req_addr  = 32'h4;
    step();
    req_valid = 1'b0;
    step();
    ld_en   = 1'b1;
    ld_addr = 32'h4;
    ld_data = 32'h5555_5555;
    step();
    ld_en = 1'b0;
    chk("race_l_valid", 32'(rsp_valid), 32'd1);
    chk("race_l_instr", rsp_instr, 32'hDEAD_BEEF);
    take("race_l");
    fetch("race_l2", 32'h4);
    chk("race_l2_instr", rsp_instr, 32'h5555_5555);
    take("race_l2");

    // Reset mid-WAIT drops the transaction; array contents persist.
    req_valid = 1'b1;
    req_addr  = 32'h0;
    step();
    req_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_ready", 32'(req_ready), 32'd1);
    chk("mrst_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_instr", rsp_instr, NOP_W);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mrst_quiet", 32'(rsp_valid), 32'd0);
    end
    fetch("mrst_f0", 32'h0);
    chk("mrst_f0_instr", rsp_instr, 32'h0050_0093);
    chk("mrst_f0_err",   32'(rsp_err), 32'd0);
    take("mrst_f0");
    fetch("mrst_last", 32'h3FC);
    chk("mrst_last_instr", rsp_instr, 32'hCAFE_F00D);
    take("mrst_last");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameters SHALL be: DEPTH, default 256, instruction words held; LATENCY, default 2, legal range 1..7, response latency in cycles.
REQ-002 Ports SHALL be, one per line:
  clk        in   1   sole clock; all state changes on its rising edge
  rst_n      in   1   reset, synchronous, active-low
  req_valid  in   1   fetch request valid
  req_ready  out  1   responder can accept a request
  req_addr   in   32  byte address of the instruction
  rsp_valid  out  1   response valid
  rsp_ready  in   1   consumer accepts the response
  rsp_instr  out  32  fetched instruction word
  rsp_err    out  1   address misaligned or out of range
  ld_en      in   1   preload write enable
  ld_addr    in   32  preload byte address (word-aligned)
  ld_data    in   32  preload word
REQ-003 The design SHALL use one clock, clk, with synchronous active-low reset rst_n.

Function
REQ-004 The block SHALL be the fetch-side responder to the PC register: one outstanding request at a time.
REQ-005 States SHALL be IDLE, WAIT and RESP; req_ready = 1 only in IDLE, and rsp_valid = 1 only in RESP.
REQ-006 A request SHALL be accepted at an edge where the state is IDLE and req_valid = 1: latch req_addr, load cnt = LATENCY-1, go to WAIT.
REQ-007 In WAIT, the block SHALL decrement cnt while cnt != 0; at an edge with cnt = 0 it latches the read result into rsp_instr/rsp_err and goes to RESP.
REQ-008 Latency SHALL be exactly LATENCY edges: accepted at edge k, rsp_valid high from edge k+LATENCY.
REQ-009 In RESP, rsp_instr, rsp_err and rsp_valid SHALL hold stable until an edge with rsp_ready = 1, then go to IDLE. No new request is accepted in that same edge.
REQ-010 Error conditions SHALL be: a latched address with addr[1:0] != 0, or with addr[31:2] >= DEPTH. Either gives rsp_err = 1 and rsp_instr = 32'h00000013 (NOP), with no array read.
REQ-011 A good address SHALL give rsp_err = 0 and rsp_instr = mem[addr[31:2]].
REQ-012 Preload: at an edge with ld_en = 1, ld_addr[1:0] = 0 and ld_addr[31:2] < DEPTH, the block SHALL write mem[ld_addr[31:2]] = ld_data. Any other ld_en write SHALL be ignored silently.
REQ-013 Preload SHALL be legal in any state.
REQ-014 A preload write to the pending address before the latch edge SHALL be visible in the response. A write in the latch edge itself SHALL NOT be visible (old data returned).
REQ-015 A preload write SHALL NOT alter an already-latched rsp_instr in RESP.
REQ-016 The transition sequence SHALL be IDLE→WAIT→RESP→IDLE only; there SHALL be no other transitions and no unreachable-state hangs. Any illegal encoding SHALL go to IDLE.

Reset
REQ-017 At an edge with rst_n = 0 the block SHALL set state = IDLE, cnt = 0, rsp_valid = 0, rsp_instr = 32'h00000013, rsp_err = 0; req_ready = 1 from the next cycle.
REQ-018 Reset during WAIT or RESP SHALL drop the transaction, with no response produced afterwards.
REQ-019 Reset SHALL NOT clear the instruction array; contents persist.

Structure
REQ-020 State encodings (IDLE/WAIT/RESP) and the NOP constant SHALL live in the shared defines file alongside NEW_PC/PC_PLUS4.
REQ-021 Storage SHALL be one sub-module, imem_array: DEPTH x 32, one synchronous write port and one combinational read port. The FSM, counter and error checks stay in imem_responder.

Verification
REQ-022 Scenario — preload and fetch: preload mem[0] = 32'h00500093; request 0x0 with LATENCY = 2 → rsp_valid exactly 2 edges after acceptance, rsp_instr = 32'h00500093, rsp_err = 0.
REQ-023 Scenario — misaligned: request 0x2 → rsp_err = 1, rsp_instr = 32'h00000013.
REQ-024 Scenario — out of range: request 0x400 with DEPTH = 256 → rsp_err = 1, rsp_instr = 32'h00000013.
REQ-025 Scenario — backpressure: rsp_ready held 0 for 5 cycles → outputs stable and req_ready = 0 throughout; with rsp_ready = 1, IDLE on the next edge.
REQ-026 Scenario — preload race: request 0x4, then write mem[1] = 32'hDEADBEEF during WAIT before the latch edge → 32'hDEADBEEF returned. The same write in RESP → the old word stays on rsp_instr.
REQ-027 Scenario — reset mid-WAIT: rst_n = 0 for 1 cycle → rsp_valid never asserts, req_ready = 1 afterwards, and mem contents are unchanged on refetch.
